// File: rtl/regfile_checker.sv
// regfile_checker: walks a small expectation table, reads each listed
// register through a combinational register-file read port, compares the
// value under a per-entry mask and reports pass/fail, the number of
// mismatching entries and the first mismatch seen in the run.
module regfile_checker #(
    parameter int NUM_CHECKS    = 4,
    parameter int WIDTH         = 32,
    parameter int ADDR_W        = 5,
    parameter int SETTLE_CYCLES = 2,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_W = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_wr_idx,
    input  logic [ADDR_W-1:0] exp_wr_addr,
    input  logic [WIDTH-1:0]  exp_wr_data,
    input  logic [WIDTH-1:0]  exp_wr_mask,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [WIDTH-1:0]  rf_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [WIDTH-1:0]  first_fail_data
);

    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W:0]   NUM_WIDE  = (IDX_W + 1)'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(NUM_CHECKS);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        READ   = 3'd2,
        CMP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Masked compare: any differing bit that the mask selects is a mismatch.
    function automatic logic masked_mismatch(
        input logic [WIDTH-1:0] observed,
        input logic [WIDTH-1:0] expected,
        input logic [WIDTH-1:0] mask
    );
        return |((observed ^ expected) & mask);
    endfunction

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [SET_W-1:0]     settle_cnt_r;
    logic [WIDTH-1:0]     captured_r;
    logic [ADDR_W-1:0]    tbl_addr_r [NUM_CHECKS];
    logic [WIDTH-1:0]     tbl_data_r [NUM_CHECKS];
    logic [WIDTH-1:0]     tbl_mask_r [NUM_CHECKS];

    logic [IDX_W-1:0]     idx_next_s;
    logic                 mismatch_s;
    logic                 wr_ok_s;

    // Next entry index and the masked comparison for the current entry.
    always_comb begin
        idx_next_s = idx_r + IDX_W'(1);
        mismatch_s = masked_mismatch(captured_r, tbl_data_r[idx_r], tbl_mask_r[idx_r]);
        if (exp_wr_en && !busy && ({1'b0, exp_wr_idx} < NUM_WIDE)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Expectation table: cleared by reset, written only while no run is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_addr_r[i] <= '0;
                tbl_data_r[i] <= '0;
                tbl_mask_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            tbl_addr_r[exp_wr_idx] <= exp_wr_addr;
            tbl_data_r[exp_wr_idx] <= exp_wr_data;
            tbl_mask_r[exp_wr_idx] <= exp_wr_mask;
        end
    end

    // Run sequencer with registered status outputs. rf_rd_addr is loaded on
    // the edge that enters READ so it is valid for the whole READ cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            idx_r           <= '0;
            settle_cnt_r    <= '0;
            captured_r      <= '0;
            rf_rd_addr      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        fail_count      <= '0;
                        first_fail_idx  <= '0;
                        first_fail_data <= '0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        idx_r           <= '0;
                        busy            <= 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            state_r    <= READ;
                            rf_rd_addr <= tbl_addr_r[0];
                        end else begin
                            state_r      <= SETTLE;
                            settle_cnt_r <= SETTLE_LD;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r <= SET_W'(1)) begin
                        settle_cnt_r <= '0;
                        state_r      <= READ;
                        rf_rd_addr   <= tbl_addr_r[idx_r];
                    end else begin
                        settle_cnt_r <= settle_cnt_r - SET_W'(1);
                    end
                end
                READ: begin
                    captured_r <= rf_rd_data;
                    rf_rd_addr <= '0;
                    state_r    <= CMP;
                end
                CMP: begin
                    if (mismatch_s) begin
                        if (fail_count != CNT_MAX) begin
                            fail_count <= fail_count + CNT_W'(1);
                        end else begin
                            fail_count <= fail_count;
                        end
                        if (fail_count == '0) begin
                            first_fail_idx  <= idx_r;
                            first_fail_data <= captured_r;
                        end else begin
                            first_fail_idx  <= first_fail_idx;
                        end
                    end else begin
                        fail_count <= fail_count;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (fail_count == '0) && !mismatch_s;
                    end else begin
                        idx_r      <= idx_next_s;
                        rf_rd_addr <= tbl_addr_r[idx_next_s];
                        state_r    <= READ;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    rf_rd_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_checker.sv
// Self-checking bench for regfile_checker: a behavioural register file feeds
// the read port, expected run results are pushed to a scoreboard at start and
// popped when done rises.
module tb_regfile_checker;

    localparam int N      = 4;
    localparam int W      = 32;
    localparam int AW     = 5;
    localparam int SC     = 2;
    localparam int IW     = 2;
    localparam int CW     = 3;
    localparam int RUNLEN = SC + 2 * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          exp_wr_en = 1'b0;
    logic [IW-1:0] exp_wr_idx = '0;
    logic [AW-1:0] exp_wr_addr = '0;
    logic [W-1:0]  exp_wr_data = '0;
    logic [W-1:0]  exp_wr_mask = '0;
    logic [AW-1:0] rf_rd_addr;
    logic [W-1:0]  rf_rd_data;
    logic          busy, done, pass;
    logic [CW-1:0] fail_count;
    logic [IW-1:0] first_fail_idx;
    logic [W-1:0]  first_fail_data;

    logic [W-1:0]  regs [32];
    logic [AW-1:0] m_addr [N];
    logic [W-1:0]  m_data [N];
    logic [W-1:0]  m_mask [N];

    typedef struct {
        logic          pass;
        logic [CW-1:0] fcount;
        logic [IW-1:0] fidx;
        logic [W-1:0]  fdata;
        int            cycles;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    assign rf_rd_data = regs[rf_rd_addr];

    always #5 clk = ~clk;

    regfile_checker #(.NUM_CHECKS(N), .WIDTH(W), .ADDR_W(AW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_addr(exp_wr_addr),
        .exp_wr_data(exp_wr_data), .exp_wr_mask(exp_wr_mask),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int idx, input logic [AW-1:0] a,
                               input logic [W-1:0] d, input logic [W-1:0] m);
        exp_wr_en = 1'b1; exp_wr_idx = IW'(idx);
        exp_wr_addr = a; exp_wr_data = d; exp_wr_mask = m;
        tick();
        exp_wr_en = 1'b0;
        m_addr[idx] = a; m_data[idx] = d; m_mask[idx] = m;
    endtask

    // Model of one run, computed from the bench copies of table and regfile.
    task automatic push_expected();
        exp_t e;
        e.pass = 1'b1; e.fcount = '0; e.fidx = '0; e.fdata = '0; e.cycles = RUNLEN;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v;
            v = regs[m_addr[i]];
            if (((v ^ m_data[i]) & m_mask[i]) != '0) begin
                if (e.fcount == '0) begin
                    e.fidx = IW'(i);
                    e.fdata = v;
                end
                e.fcount = e.fcount + CW'(1);
                e.pass = 1'b0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic start_run(input bit expect_result);
        if (expect_result) push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, input string name);
        int n;
        exp_t e;
        n = already;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
            bad++;
        end
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard: queue empty, required an entry", name);
        end else begin
            e = sb.pop_front();
            total++;
            if (n !== e.cycles) begin
                $display("FAIL %s latency: got %0d cycles, required %0d", name, n, e.cycles); bad++;
            end
            total++;
            if (pass !== e.pass) begin
                $display("FAIL %s pass: got %b, required %b", name, pass, e.pass); bad++;
            end
            total++;
            if (fail_count !== e.fcount) begin
                $display("FAIL %s fail_count: got %0d, required %0d", name, fail_count, e.fcount); bad++;
            end
            total++;
            if (first_fail_idx !== e.fidx) begin
                $display("FAIL %s first_fail_idx: got %0d, required %0d", name, first_fail_idx, e.fidx); bad++;
            end
            total++;
            if (first_fail_data !== e.fdata) begin
                $display("FAIL %s first_fail_data: got %h, required %h", name, first_fail_data, e.fdata); bad++;
            end
        end
        total++;
        if (busy !== 1'b0 || rf_rd_addr !== '0) begin
            $display("FAIL %s idle outputs at done: busy=%b addr=%0d, required 0 0", name, busy, rf_rd_addr); bad++;
        end
    endtask

    task automatic check_cleared(input string name);
        total++;
        if ({busy, done, pass} !== 3'b000 || fail_count !== '0 || first_fail_idx !== '0
            || first_fail_data !== '0 || rf_rd_addr !== '0) begin
            $display("FAIL %s: busy=%b done=%b pass=%b fc=%0d ffi=%0d ffd=%h addr=%0d, required all 0",
                     name, busy, done, pass, fail_count, first_fail_idx, first_fail_data, rf_rd_addr);
            bad++;
        end
    endtask

    task automatic load_std_table();
        write_entry(0, 5'd9, 32'd1, 32'hFFFF_FFFF);
        write_entry(1, 5'd10, 32'd2, 32'hFFFF_FFFF);
        write_entry(2, 5'd11, 32'd2, 32'hFFFF_FFFF);
        write_entry(3, 5'd12, 32'd6, 32'hFFFF_FFFF);
        regs[9] = 32'd1; regs[10] = 32'd2; regs[11] = 32'd2; regs[12] = 32'd6;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_cleared("reset_state");
    endtask

    task automatic test_all_pass();
        load_std_table();
        start_run(1'b1);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_after_start: got %b, required 1", busy); bad++;
        end
        wait_done(0, "all_pass");
    endtask

    task automatic test_single_fail();
        regs[11] = 32'd3;
        start_run(1'b1);
        wait_done(0, "single_fail");
        regs[11] = 32'd2;
    endtask

    task automatic test_mask();
        write_entry(3, 5'd12, 32'd6, 32'h0000_0001);
        regs[12] = 32'd4;
        start_run(1'b1);
        wait_done(0, "mask_pass");
        write_entry(3, 5'd12, 32'd6, 32'h0000_0004);
        regs[12] = 32'd2;
        start_run(1'b1);
        wait_done(0, "mask_fail");
        write_entry(3, 5'd12, 32'd6, 32'hFFFF_FFFF);
        regs[12] = 32'd6;
    endtask

    task automatic test_ignore_busy();
        start_run(1'b1);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_wr_en = 1'b1; exp_wr_idx = 2'd0; exp_wr_addr = 5'd3;
        exp_wr_data = 32'hDEAD_BEEF; exp_wr_mask = 32'hFFFF_FFFF;
        tick();
        exp_wr_en = 1'b0;
        wait_done(4, "ignore_busy");
        start_run(1'b1);
        wait_done(0, "table_unchanged");
    endtask

    task automatic test_mid_reset();
        regs[10] = 32'd77;
        start_run(1'b0);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("mid_reset");
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0;
        end
        regs[10] = 32'd2;
        regs[0] = 32'h0000_0055;
        start_run(1'b1);
        wait_done(0, "zeroed_table");
        regs[0] = '0;
    endtask

    task automatic test_two_fail_restart();
        load_std_table();
        regs[10] = 32'd7;
        regs[12] = 32'd9;
        start_run(1'b1);
        wait_done(0, "two_fail");
        regs[10] = 32'd2;
        regs[12] = 32'd6;
        start_run(1'b1);
        wait_done(0, "restart_pass");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0;
        end
        test_reset();
        test_all_pass();
        test_single_fail();
        test_mask();
        test_ignore_busy();
        test_mid_reset();
        test_two_fail_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
